// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, branch flush and saturating event counters
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_alusrc,
    input  logic              id_memtoreg,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic [1:0]        id_aluop,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              ex_br_taken,
    output logic              ex_valid,
    output logic              ex_alusrc,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic [1:0]        ex_aluop,
    output logic [PC_W-1:0]   ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              stall,
    output logic              flush_ifid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
        logic [4:0] rd;
    } ctrl_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
    } data_t;

    ctrl_t            ctrl_d, ctrl_q;
    data_t            data_d, data_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
    logic             uses_rs1, uses_rs2, hazard;

    assign uses_rs1   = id_aluop != 2'b11;
    assign uses_rs2   = !id_alusrc || id_memwrite;
    assign hazard     = ctrl_q.valid && ctrl_q.memread && ctrl_q.rd != 5'd0 && id_valid &&
                        ((uses_rs1 && ctrl_q.rd == id_rs1) || (uses_rs2 && ctrl_q.rd == id_rs2));
    assign flush_ifid = ctrl_q.valid && ctrl_q.branch && ex_br_taken;
    assign stall      = hazard && !flush_ifid;

    assign {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop, ex_rd} = ctrl_q;
    assign {ex_pc, ex_rs1, ex_rs2, ex_rd1, ex_rd2, ex_imm, ex_funct3, ex_funct7} = data_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Next state: a bubble (all control zero) on flush, hazard or an empty ID slot; data always follows ID
    always_comb begin
        ctrl_d      = (flush_ifid || hazard || !id_valid) ? '0 :
                      {1'b1, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop, id_rd};
        data_d      = {id_pc, id_rs1, id_rs2, id_rd1, id_rd2, id_imm, id_funct3, id_funct7};
        stall_cnt_d = stall_cnt_q + CNT_W'(stall && stall_cnt_q != '1);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_ifid && flush_cnt_q != '1);
    end

    // Pipeline and counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q      <= '0;
            data_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of the ID/EX register, hazard/flush logic and counter saturation
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
    logic [1:0]  id_aluop;
    logic [8:0]  id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        ex_br_taken;

    logic        ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [1:0]  ex_aluop;
    logic [8:0]  ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rd1, ex_rd2, ex_imm;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        stall, flush_ifid;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_valid, s_alusrc, s_memtoreg, s_regwrite, s_memread, s_memwrite, s_branch;
    logic [1:0]  s_aluop;
    logic [8:0]  s_pc;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [31:0] s_rd1, s_rd2, s_imm;
    logic [2:0]  s_funct3;
    logic [6:0]  s_funct7;
    logic        s_stall, s_flush_ifid;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] last_pc;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_aluop(id_aluop), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .ex_br_taken(ex_br_taken), .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
        .ex_aluop(ex_aluop), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .stall(stall), .flush_ifid(flush_ifid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
        .id_aluop(id_aluop), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .ex_br_taken(ex_br_taken), .ex_valid(s_valid), .ex_alusrc(s_alusrc), .ex_memtoreg(s_memtoreg),
        .ex_regwrite(s_regwrite), .ex_memread(s_memread), .ex_memwrite(s_memwrite), .ex_branch(s_branch),
        .ex_aluop(s_aluop), .ex_pc(s_pc), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
        .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_funct3(s_funct3), .ex_funct7(s_funct7),
        .stall(s_stall), .flush_ifid(s_flush_ifid), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic alusrc, input logic memtoreg, input logic regwrite,
                         input logic memread, input logic memwrite, input logic branch, input logic [1:0] aluop,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
        id_valid    = v;
        id_alusrc   = alusrc;
        id_memtoreg = memtoreg;
        id_regwrite = regwrite;
        id_memread  = memread;
        id_memwrite = memwrite;
        id_branch   = branch;
        id_aluop    = aluop;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_imm      = imm;
        id_pc       = id_pc + 9'd4;
        id_rd1      = 32'h1000 + 32'(rs1);
        id_rd2      = 32'h2000 + 32'(rs2);
        id_funct3   = rd[2:0];
        id_funct7   = {2'b00, rs2};
        last_pc     = id_pc;
    endtask

    task automatic ld(input logic [4:0] rd);
        drive(1, 1, 1, 1, 1, 0, 0, 2'b00, 5'd2, 5'd0, rd, 32'd8);
    endtask

    task automatic radd(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        drive(1, 0, 0, 1, 0, 0, 0, 2'b10, rs1, rs2, rd, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        ex_br_taken = 1'b0;
        id_pc       = 9'd0;
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0);
        id_pc = 9'd0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", ex_valid, 0);
        check("rst_pc", ex_pc, 0);
        check("rst_stall", stall, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);

        radd(5'd1, 5'd2, 5'd5);
        #1 check("rtype_stall", stall, 0);
        tick();
        check("rtype_valid", ex_valid, 1);
        check("rtype_rd", ex_rd, 5);
        check("rtype_aluop", ex_aluop, 2'b10);
        check("rtype_regwrite", ex_regwrite, 1);
        check("rtype_alusrc", ex_alusrc, 0);
        check("rtype_rd1", ex_rd1, 32'h1001);
        check("rtype_rd2", ex_rd2, 32'h2002);
        check("rtype_pc", ex_pc, last_pc);
        check("rtype_funct3", ex_funct3, 3'd5);
        drive(1, 1, 0, 1, 0, 0, 0, 2'b10, 5'd5, 5'd3, 5'd6, 32'h7ff);
        #1 check("addi_stall", stall, 0);
        tick();
        check("addi_rd", ex_rd, 6);
        check("addi_alusrc", ex_alusrc, 1);
        check("addi_imm", ex_imm, 32'h7ff);
        check("addi_rs1", ex_rs1, 5);
        check("addi_funct7", ex_funct7, 7'd3);

        ld(5'd5);
        tick();
        check("lw_memread", ex_memread, 1);
        radd(5'd5, 5'd6, 5'd7);
        #1 check("lu_stall", stall, 1);
        check("lu_flush", flush_ifid, 0);
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_regwrite", ex_regwrite, 0);
        check("lu_bubble_rd", ex_rd, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_stall_drop", stall, 0);
        tick();
        check("lu_adv_valid", ex_valid, 1);
        check("lu_adv_rd", ex_rd, 7);
        check("lu_adv_stall_cnt", stall_cnt, 1);

        ld(5'd5);
        tick();
        drive(1, 1, 0, 1, 0, 0, 0, 2'b11, 5'd5, 5'd0, 5'd5, 32'h12345000);
        #1 check("lui_no_stall", stall, 0);
        tick();
        ld(5'd5);
        tick();
        drive(1, 1, 0, 1, 0, 0, 0, 2'b10, 5'd1, 5'd5, 5'd8, 32'd4);
        #1 check("addi_rs2_no_stall", stall, 0);
        tick();
        ld(5'd5);
        tick();
        drive(1, 1, 0, 0, 0, 1, 0, 2'b00, 5'd2, 5'd5, 5'd0, 32'd12);
        #1 check("sw_stall", stall, 1);
        tick();
        check("sw_stall_cnt", stall_cnt, 2);
        tick();
        check("sw_adv_valid", ex_valid, 1);
        check("sw_adv_memwrite", ex_memwrite, 1);

        ld(5'd0);
        tick();
        radd(5'd0, 5'd0, 5'd7);
        #1 check("x0_no_stall", stall, 0);
        tick();

        drive(1, 0, 0, 0, 1, 0, 1, 2'b01, 5'd5, 5'd6, 5'd5, 32'd16);
        tick();
        ex_br_taken = 1'b1;
        radd(5'd5, 5'd6, 5'd7);
        #1 check("br_flush", flush_ifid, 1);
        check("br_stall", stall, 0);
        tick();
        check("br_bubble_valid", ex_valid, 0);
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 2);
        check("br_no_flush_after", flush_ifid, 0);
        ex_br_taken = 1'b0;

        drive(0, 0, 0, 1, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd9, 32'd0);
        tick();
        check("inv_valid", ex_valid, 0);
        check("inv_regwrite", ex_regwrite, 0);
        check("inv_aluop", ex_aluop, 0);

        for (int i = 0; i < 18; i++) begin
            ld(5'd5);
            tick();
            radd(5'd5, 5'd6, 5'd7);
            tick();
        end
        check("sat_main_cnt", stall_cnt, 20);
        check("sat_small_cnt", s_stall_cnt, 15);
        check("sat_small_flush", s_flush_cnt, 1);

        ld(5'd5);
        tick();
        check("mid_memread", ex_memread, 1);
        radd(5'd5, 5'd6, 5'd7);
        #1 check("mid_stall", stall, 1);
        #2 reset = 1'b1;
        #1 check("mid_valid", ex_valid, 0);
        check("mid_memread_clr", ex_memread, 0);
        check("mid_stall_clr", stall, 0);
        check("mid_stall_cnt", stall_cnt, 0);
        check("mid_flush_cnt", flush_cnt, 0);
        check("mid_small_cnt", s_stall_cnt, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
